// File: rtl/parity_rr_scheduler_pkg.sv
// parity_rr_scheduler_pkg: shared types and the parity check helper
package parity_rr_scheduler_pkg;
    typedef enum logic {ODD, EVEN} parity_mode_t;
    typedef enum logic {MSB, LSB} parity_bit_t;
    typedef enum logic [1:0] {IDLE, CHECK, OUT} sched_state_t;
    // XOR of the whole word (parity bit included) must be 1 for ODD, 0 for EVEN
    function automatic logic parity_ok(input logic [63:0] data, input parity_mode_t mode);
        return (^data) == (mode == ODD);
    endfunction
endpackage

// File: rtl/parity_rr_scheduler_if.sv
// parity_rr_scheduler_if: FIFO-bank and top-level bus of the scheduler
interface parity_rr_scheduler_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SRC       = 4,
    parameter int ERR_CNT_WIDTH = 16
);
    localparam int IDW = $clog2(NUM_SRC);
    logic [NUM_SRC-1:0]                 src_valid_i;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data_i;
    logic [NUM_SRC-1:0]                 src_grant_o;
    logic                               valid_o;
    logic [DATA_WIDTH-1:0]              data_o;
    logic [IDW-1:0]                     src_id_o;
    logic                               grant_i;
    logic                               clear_err_i;
    logic [ERR_CNT_WIDTH-1:0]           err_cnt_o;
    logic [IDW-1:0]                     err_src_o;
    modport master (
        input  src_valid_i, src_data_i, grant_i, clear_err_i,
        output src_grant_o, valid_o, data_o, src_id_o, err_cnt_o, err_src_o
    );
    modport slave (
        output src_valid_i, src_data_i, grant_i, clear_err_i,
        input  src_grant_o, valid_o, data_o, src_id_o, err_cnt_o, err_src_o
    );
endinterface

// File: rtl/parity_rr_scheduler_rr_select.sv
// rr_select: first requester at or after ptr, searching cyclically
module rr_select #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);
    // scan offsets from farthest to nearest so the nearest hit wins
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = (int'(ptr) + i) % N;
            if (req[k]) idx = k[W-1:0];
        end
    end
endmodule

// File: rtl/parity_rr_scheduler.sv
// parity_rr_scheduler: round-robin parity checker shared by several FIFO sources
module parity_rr_scheduler
    import parity_rr_scheduler_pkg::*;
#(
    parameter int           DATA_WIDTH        = 8,
    parameter int           NUM_SRC           = 4,
    parameter parity_mode_t PARITY_MODE       = ODD,
    parameter parity_bit_t  PARITY_BIT_CHOICE = MSB,
    parameter int           ERR_CNT_WIDTH     = 16
) (
    input logic                    clk,
    input logic                    rst,
    parity_rr_scheduler_if.master  bus
);
    localparam int IDW = $clog2(NUM_SRC);

    sched_state_t             state_q, state_d;
    logic [IDW-1:0]           rr_ptr_q, rr_ptr_d, sel_q, sel_d, src_id_q, src_id_d, err_src_q, err_src_d;
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [NUM_SRC-1:0]       src_grant;
    logic                     any, inc, good, pbit, sel_valid;
    logic [IDW-1:0]           idx, sel_nxt;
    logic [DATA_WIDTH-1:0]    word;
    logic [DATA_WIDTH-2:0]    rest;

    rr_select #(.N(NUM_SRC)) u_rr_select (
        .req (bus.src_valid_i),
        .ptr (rr_ptr_q),
        .any (any),
        .idx (idx)
    );

    // parity bit is split out by position; the XOR over the whole word is position-independent
    assign word      = bus.src_data_i[sel_q];
    assign pbit      = PARITY_BIT_CHOICE == MSB ? word[DATA_WIDTH-1] : word[0];
    assign rest      = PARITY_BIT_CHOICE == MSB ? word[DATA_WIDTH-2:0] : word[DATA_WIDTH-1:1];
    assign good      = parity_ok(64'({pbit, rest}), PARITY_MODE);
    assign sel_valid = bus.src_valid_i[sel_q];
    assign sel_nxt   = sel_q == IDW'(NUM_SRC - 1) ? '0 : sel_q + 1'b1;

    // next state, pop strobes and error counter update
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        data_d    = data_q;
        src_id_d  = src_id_q;
        err_src_d = err_src_q;
        src_grant = '0;
        inc       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    sel_d   = idx;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (good) begin
                    data_d   = word;
                    src_id_d = sel_q;
                    valid_d  = 1'b1;
                    state_d  = OUT;
                end else begin
                    src_grant[sel_q] = 1'b1;
                    inc              = 1'b1;
                    err_src_d        = sel_q;
                    rr_ptr_d         = sel_nxt;
                    state_d          = IDLE;
                end
            end
            OUT: begin
                if (!sel_valid) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.grant_i) begin
                    src_grant[sel_q] = 1'b1;
                    rr_ptr_d         = sel_nxt;
                    valid_d          = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_cnt_d = bus.clear_err_i ? ERR_CNT_WIDTH'(inc) : err_cnt_q + ERR_CNT_WIDTH'(inc && !(&err_cnt_q));
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            src_id_q  <= '0;
            err_cnt_q <= '0;
            err_src_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            src_id_q  <= src_id_d;
            err_cnt_q <= err_cnt_d;
            err_src_q <= err_src_d;
        end
    end

    assign bus.src_grant_o = src_grant;
    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.src_id_o    = src_id_q;
    assign bus.err_cnt_o   = err_cnt_q;
    assign bus.err_src_o   = err_src_q;
endmodule

// File: tb/tb_parity_rr_scheduler.sv
// tb_parity_rr_scheduler: directed and randomized checks against a transaction-level model
module tb_parity_rr_scheduler;
    import parity_rr_scheduler_pkg::*;

    typedef struct {
        bit         bad;
        int         id;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parity_rr_scheduler_if #(.DATA_WIDTH(8), .NUM_SRC(4), .ERR_CNT_WIDTH(16)) bus ();
    parity_rr_scheduler_if #(.DATA_WIDTH(8), .NUM_SRC(4), .ERR_CNT_WIDTH(2))  bus2 ();

    parity_rr_scheduler #(.DATA_WIDTH(8), .NUM_SRC(4), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB), .ERR_CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    parity_rr_scheduler #(.DATA_WIDTH(8), .NUM_SRC(4), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB), .ERR_CNT_WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fq [4][$];
    logic [3:0] pend;

    function automatic bit good_word(input logic [7:0] w);
        return (^w) == 1'b1;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            bus.src_valid_i[i] = fq[i].size() != 0;
            bus.src_data_i[i]  = fq[i].size() != 0 ? fq[i][0] : 8'h00;
        end
    endtask

    // FIFO bank model: a pop strobe seen mid-cycle removes the head just after the edge
    always begin
        @(negedge clk);
        pend = bus.src_grant_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pend[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        drive_srcs();
    end

    task automatic at_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        at_drive();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) fq[i].delete();
        drive_srcs();
        bus.grant_i      = 1'b0;
        bus.clear_err_i  = 1'b0;
        bus2.src_valid_i = '0;
        bus2.clear_err_i = 1'b0;
        at_drive();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        at_neg();
        n_checks++;
        if ({bus.valid_o, bus.data_o, bus.src_id_o, bus.src_grant_o, bus.err_cnt_o, bus.err_src_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b d=%h id=%0d g=%b cnt=%0d es=%0d, expected all zero",
                     bus.valid_o, bus.data_o, bus.src_id_o, bus.src_grant_o, bus.err_cnt_o, bus.err_src_o);
        end
        at_drive();
        rst = 1'b0;
        fq[1].push_back(8'h80);
        drive_srcs();
        bus.grant_i = 1'b1;
        k = 0;
        do begin at_neg(); k++; end while (bus.src_grant_o == 4'b0000 && k < 10);
        n_checks++;
        if (bus.src_grant_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_pre_serve: src_grant_o=%b expected 0010", bus.src_grant_o);
        end
        at_drive();
        bus.grant_i = 1'b0;
        fq[3].push_back(8'h80);
        drive_srcs();
        k = 0;
        do begin at_neg(); k++; end while (!bus.valid_o && k < 10);
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.src_id_o !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_pre_out: valid_o=%b src_id_o=%0d expected 1 and 3", bus.valid_o, bus.src_id_o);
        end
        #2;
        rst = 1'b1;
        bus.grant_i = 1'b1;
        #1;
        n_checks++;
        if ({bus.valid_o, bus.data_o, bus.src_id_o, bus.src_grant_o, bus.err_cnt_o, bus.err_src_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_out: got v=%b d=%h id=%0d g=%b, expected all zero",
                     bus.valid_o, bus.data_o, bus.src_id_o, bus.src_grant_o);
        end
        at_drive();
        for (int i = 0; i < 4; i++) fq[i].delete();
        fq[0].push_back(8'h01);
        fq[3].push_back(8'h80);
        drive_srcs();
        rst = 1'b0;
        k = 0;
        do begin at_neg(); k++; end while (!bus.valid_o && k < 10);
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.src_id_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ptr_cleared: valid_o=%b src_id_o=%0d expected 1 and 0", bus.valid_o, bus.src_id_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] exp_g [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic       exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        at_drive();
        fq[0].push_back(8'h01);
        drive_srcs();
        bus.grant_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            n_checks++;
            if (bus.valid_o !== exp_v[c] || bus.src_grant_o !== exp_g[c] || (exp_v[c] && (bus.data_o !== 8'h01 || bus.src_id_o !== 2'd0))) begin
                n_fail++;
                $display("FAIL single_cycle%0d: v=%b g=%b d=%h id=%0d expected v=%b g=%b d=01 id=0",
                         c, bus.valid_o, bus.src_grant_o, bus.data_o, bus.src_id_o, exp_v[c], exp_g[c]);
            end
        end
        do_reset();
    endtask

    task automatic test_bad();
        at_drive();
        fq[2].push_back(8'h03);
        drive_srcs();
        bus.grant_i = 1'b1;
        at_neg();
        at_neg();
        n_checks++;
        if (bus.src_grant_o !== 4'b0100 || bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_drop_pop: g=%b v=%b expected 0100 and 0", bus.src_grant_o, bus.valid_o);
        end
        at_neg();
        n_checks++;
        if (bus.err_cnt_o !== 16'd1 || bus.err_src_o !== 2'd2 || bus.valid_o !== 1'b0 || bus.src_grant_o !== 4'b0000 || fq[2].size() != 0) begin
            n_fail++;
            $display("FAIL bad_drop_count: cnt=%0d es=%0d v=%b g=%b left=%0d expected 1 2 0 0000 0",
                     bus.err_cnt_o, bus.err_src_o, bus.valid_o, bus.src_grant_o, fq[2].size());
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        int got [$];
        int last;
        at_drive();
        fq[0].push_back(8'h01);
        fq[1].push_back(8'h02);
        fq[2].push_back(8'h04);
        fq[3].push_back(8'h08);
        fq[0].push_back(8'h10);
        drive_srcs();
        bus.grant_i = 1'b1;
        last = -1;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            at_neg();
            if (bus.valid_o && bus.src_grant_o != 4'b0000) begin
                got.push_back(int'(bus.src_id_o));
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != 3) begin
                        n_fail++;
                        $display("FAIL rr_throughput: gap=%0d cycles expected 3", c - last);
                    end
                end
                last = c;
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] != exp_id[i]) begin
                n_fail++;
                $display("FAIL rr_order%0d: got %0d expected %0d", i, i < got.size() ? got[i] : -1, exp_id[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        int         k;
        logic [7:0] d;
        at_drive();
        fq[1].push_back(8'h02);
        fq[1].push_back(8'h04);
        drive_srcs();
        k = 0;
        do begin at_neg(); k++; end while (!bus.valid_o && k < 10);
        d = bus.data_o;
        n_checks++;
        if (bus.valid_o !== 1'b1 || d !== 8'h02) begin
            n_fail++;
            $display("FAIL bp_present: v=%b d=%h expected 1 02", bus.valid_o, d);
        end
        for (int c = 0; c < 10; c++) begin
            at_neg();
            n_checks++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h02 || bus.src_grant_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b d=%h g=%b expected 1 02 0000", c, bus.valid_o, bus.data_o, bus.src_grant_o);
            end
        end
        at_drive();
        bus.grant_i = 1'b1;
        at_neg();
        n_checks++;
        if (bus.src_grant_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release: g=%b expected 0010", bus.src_grant_o);
        end
        at_drive();
        bus.grant_i = 1'b0;
        at_neg();
        n_checks++;
        if (fq[1].size() != 1 || bus.src_grant_o !== 4'b0000 || bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_single_pop: left=%0d g=%b v=%b expected 1 0000 0", fq[1].size(), bus.src_grant_o, bus.valid_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] mq [4][$];
        ev_t        exp_q [$];
        ev_t        e;
        int         ptr, cyc, exp_cnt, exp_src;
        bit         chk;
        logic [7:0] w;
        for (int i = 0; i < 4; i++) begin
            int n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                w = 8'($urandom);
                fq[i].push_back(w);
                mq[i].push_back(w);
            end
        end
        ptr = 0;
        while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0) begin
            int j = -1;
            for (int off = 0; off < 4 && j < 0; off++)
                if (mq[(ptr + off) % 4].size() != 0) j = (ptr + off) % 4;
            w = mq[j].pop_front();
            exp_q.push_back('{!good_word(w), j, w});
            ptr = (j + 1) % 4;
        end
        at_drive();
        drive_srcs();
        cyc = 0; exp_cnt = 0; exp_src = 0; chk = 0;
        while ((exp_q.size() != 0 || chk) && cyc < 3000) begin
            at_drive();
            bus.grant_i = $urandom_range(0, 2) != 0;
            at_neg();
            cyc++;
            if (chk) begin
                n_checks++;
                if (bus.err_cnt_o !== 16'(exp_cnt) || bus.err_src_o !== 2'(exp_src)) begin
                    n_fail++;
                    $display("FAIL rand_err: cnt=%0d es=%0d expected %0d %0d", bus.err_cnt_o, bus.err_src_o, exp_cnt, exp_src);
                end
                chk = 0;
            end
            if (bus.src_grant_o != 4'b0000) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_pop: g=%b expected no pop", bus.src_grant_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.valid_o) begin
                        if (e.bad || !bus.grant_i || bus.src_id_o !== 2'(e.id) || bus.data_o !== e.data || bus.src_grant_o !== 4'(1 << e.id)) begin
                            n_fail++;
                            $display("FAIL rand_accept: id=%0d d=%h g=%b expected bad=%0d id=%0d d=%h",
                                     bus.src_id_o, bus.data_o, bus.src_grant_o, e.bad, e.id, e.data);
                        end
                    end else begin
                        if (!e.bad || bus.src_grant_o !== 4'(1 << e.id)) begin
                            n_fail++;
                            $display("FAIL rand_drop: g=%b expected bad=%0d id=%0d d=%h", bus.src_grant_o, e.bad, e.id, e.data);
                        end
                        exp_cnt++;
                        exp_src = e.id;
                        chk = 1;
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout: %0d events outstanding, expected 0", exp_q.size());
        end
        do_reset();
    endtask

    task automatic test_saturate();
        int drops = 0;
        int k;
        do_reset();
        bus2.src_data_i    = '0;
        bus2.src_data_i[0] = 8'h03;
        bus2.src_valid_i   = 4'b0001;
        k = 0;
        while (drops < 5 && k < 40) begin
            at_neg();
            k++;
            n_checks++;
            if (bus2.err_cnt_o !== 2'(drops > 3 ? 3 : drops)) begin
                n_fail++;
                $display("FAIL sat_count: cnt=%0d expected %0d", bus2.err_cnt_o, drops > 3 ? 3 : drops);
            end
            if (bus2.src_grant_o != 4'b0000) drops++;
        end
        at_neg();
        n_checks++;
        if (bus2.err_cnt_o !== 2'd3 || drops != 5) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d drops=%0d expected 3 5", bus2.err_cnt_o, drops);
        end
        k = 0;
        do begin at_neg(); k++; end while (bus2.src_grant_o == 4'b0000 && k < 10);
        bus2.clear_err_i = 1'b1;
        at_drive();
        bus2.clear_err_i = 1'b0;
        at_neg();
        n_checks++;
        if (bus2.err_cnt_o !== 2'd1 || bus2.err_src_o !== 2'd0) begin
            n_fail++;
            $display("FAIL clear_with_drop: cnt=%0d es=%0d expected 1 0", bus2.err_cnt_o, bus2.err_src_o);
        end
        bus2.src_valid_i = '0;
    endtask

    initial begin
        bus.grant_i      = 1'b0;
        bus.clear_err_i  = 1'b0;
        bus2.grant_i     = 1'b0;
        bus2.clear_err_i = 1'b0;
        bus2.src_valid_i = '0;
        bus2.src_data_i  = '0;
        drive_srcs();
        test_reset();
        test_single();
        test_bad();
        test_round_robin();
        test_backpressure();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
